// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select width and default widths for the registered demultiplexer
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one output channel holding slot with valid flag and wrapping delivery counter
module demux_slot #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      count <= '0;
    end else begin
      if (load) data <= load_data;
      valid <= load || (valid && !take);
      if (valid && take) count <= count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: registered 1-to-4 demultiplexer with per-channel valid/ready slots and delivery counters
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*CNT_W-1:0] out_count
);
  logic [NUM_CH-1:0] load;
  assign in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = in_valid && in_ready && in_sel == SEL_W'(i);
    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_data (in_data),
      .take      (out_ready[i]),
      .data      (out_data[i*WIDTH +: WIDTH]),
      .valid     (out_valid[i]),
      .count     (out_count[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux_1to4_reg.sv
// tb_demux_1to4_reg: randomized scoreboard bench for the registered 1-to-4 demultiplexer
module tb_demux_1to4_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] out_count;
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[4][$];
  bit         occ[4];
  logic [7:0] mon_cnt[4];
  demux_1to4_reg #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(input bit v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
    bit exp_rdy;
    @(negedge clk);
    in_valid = v;
    in_sel = s;
    in_data = d;
    out_ready = r;
    #1;
    exp_rdy = !occ[s] || r[s];
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    for (int k = 0; k < 4; k++) chk($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(occ[k]));
    for (int k = 0; k < 4; k++) if (occ[k] && r[k]) occ[k] = 1'b0;
    if (v && exp_rdy) begin
      occ[s] = 1'b1;
      exp_q[s].push_back(d);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 4'($urandom);
    #1;
    chk("in_ready_rst", int'(in_ready), 0);
    @(negedge clk);
    #1;
    chk("in_ready_rst", int'(in_ready), 0);
    chk("out_valid_rst", int'(out_valid), 0);
    chk("out_data_rst", int'(out_data), 0);
    chk("out_count_rst", int'(out_count != 0), 0);
    for (int k = 0; k < 4; k++) begin
      occ[k] = 1'b0;
      exp_q[k].delete();
    end
    rst = 1'b0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        for (int k = 0; k < 4; k++) mon_cnt[k] = '0;
        continue;
      end
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_count[%0d]", k), int'(out_count[k*8 +: 8]), int'(mon_cnt[k]));
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) chk($sformatf("spurious_delivery[%0d]", k), 1, 0);
          else chk($sformatf("out_data[%0d]", k), int'(out_data[k*4 +: 4]), int'(exp_q[k].pop_front()));
          mon_cnt[k]++;
        end
      end
    end
  end
  initial begin
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 4'(i), 4'hF);
    cycle(1'b0, 2'd0, 4'd0, 4'hF);
    cycle(1'b1, 2'd2, 4'hD, 4'b1011);
    cycle(1'b1, 2'd2, 4'hC, 4'b1011);
    cycle(1'b1, 2'd2, 4'hC, 4'b1111);
    cycle(1'b1, 2'd1, 4'h7, 4'b0101);
    cycle(1'b1, 2'd0, 4'hF, 4'b0101);
    cycle(1'b0, 2'd0, 4'h0, 4'b0101);
    cycle(1'b1, 2'd3, 4'hE, 4'hF);
    cycle(1'b1, 2'd3, 4'hD, 4'hF);
    cycle(1'b1, 2'd3, 4'hC, 4'hF);
    cycle(1'b0, 2'd0, 4'h0, 4'hF);
    for (int i = 0; i < 257; i++) cycle(1'b1, 2'd0, 4'(i), 4'b0001);
    for (int i = 0; i < 400; i++) cycle(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    cycle(1'b1, 2'd1, 4'h9, 4'b0000);
    cycle(1'b1, 2'd2, 4'h6, 4'b0000);
    do_reset();
    cycle(1'b0, 2'd0, 4'h0, 4'hF);
    for (int i = 0; i < 300; i++) cycle(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 4'h0, 4'hF);
    @(negedge clk);
    #3;
    for (int k = 0; k < 4; k++) chk($sformatf("undelivered[%0d]", k), exp_q[k].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
